// File: rtl/m9312_boot_if.sv
// m9312_boot_if
// Unibus-style bus bundle seen by the bootstrap/terminator ROM card.
//   bus_addr     : 18-bit bus address            (master -> card)
//   bus_msyn     : master sync                   (master -> card)
//   bus_pwr_lo   : power-low, level sensitive    (master -> card)
//   bus_ssyn     : slave sync                    (card -> master)
//   bus_d_out    : read data, 0 when unselected  (card -> master)
//   bus_addr_out : power-up vector override      (card -> master)
interface m9312_boot_if;
   logic [17:0] bus_addr;
   logic        bus_msyn;
   logic        bus_pwr_lo;
   logic        bus_ssyn;
   logic [15:0] bus_d_out;
   logic [17:0] bus_addr_out;

   modport master (
      output bus_addr, bus_msyn, bus_pwr_lo,
      input  bus_ssyn, bus_d_out, bus_addr_out
   );

   modport slave (
      input  bus_addr, bus_msyn, bus_pwr_lo,
      output bus_ssyn, bus_d_out, bus_addr_out
   );
endinterface

// File: rtl/m9312_boot.sv
// m9312_boot
// Bootstrap/terminator ROM card: a 256-word diagnostic ROM in the low window,
// NSOCK boot sockets in the high window with a console/offset switch overlay
// on one word, a programmable SSYN delay, a host ROM-load port and a
// power-up vector override state machine.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   enable          : card present; 0 hides the card completely
//   bus             : m9312_boot_if.slave bus bundle
//   sw_offset       : boot offset switches, ORed into bits 8:0 of the switch word
//   sw_cons         : console-boot switch, inverts bits 12:10 of the switch word
//   sw_ovr          : runtime enable of the power-up override
//   rom_we/rom_sel  : host write strobe, 0 = low ROM, 1 = high ROM
//   rom_waddr/wdata : host write word address and data
//   boot_active     : vector override currently asserted
module m9312_boot #(
   parameter int          NSOCK       = 4,
   parameter logic [8:0]  LO_BASE     = 9'o765,
   parameter logic [8:0]  HI_BASE     = 9'o773,
   parameter logic [7:0]  SW_WORD     = 8'o012,
   parameter int          SSYN_DLY    = 16,
   parameter int          PWR_TIMEOUT = 'o10000,
   parameter logic [17:0] VECTOR      = 18'o773000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   m9312_boot_if.slave       bus,
   input  logic [8:0]        sw_offset,
   input  logic              sw_cons,
   input  logic              sw_ovr,
   input  logic              rom_we,
   input  logic              rom_sel,
   input  logic [8:0]        rom_waddr,
   input  logic [15:0]       rom_wdata,
   output logic              boot_active
);

   localparam logic [7:0]    SSYN_MAX  = 8'(SSYN_DLY);
   localparam int            TW        = $clog2(PWR_TIMEOUT + 1);
   localparam logic [TW-1:0] TIMER_MAX = TW'(PWR_TIMEOUT);
   localparam logic [3:0]    NSOCK_L   = 4'(NSOCK);

   typedef enum logic [1:0] {IDLE, ARMED, DONE} vec_state_t;

   logic [15:0] rom_lo [256];
   logic [15:0] rom_hi [256];

   logic        sel_lo;
   logic        sel_hi;
   logic        sel;
   logic [7:0]  word_idx;
   logic [15:0] hi_word;
   logic [15:0] d_q;
   logic        ssyn_q;
   logic [7:0]  ssyn_cnt;

   vec_state_t    state, state_n;
   logic [TW-1:0] timer, timer_n;
   logic [1:0]    msyn_cnt, msyn_cnt_n;
   logic          msyn_prev;
   logic          msyn_fall;

   logic unused_addr_bit;
   assign unused_addr_bit = bus.bus_addr[0];

   assign word_idx = bus.bus_addr[8:1];

   // Sockets are decoded from bus_addr[8:6]; unpopulated sockets never answer.
   always_comb begin
      sel_lo = enable & bus.bus_msyn & (bus.bus_addr[17:9] == LO_BASE);
      sel_hi = enable & bus.bus_msyn & (bus.bus_addr[17:9] == HI_BASE)
               & ({1'b0, bus.bus_addr[8:6]} < NSOCK_L);
      sel    = sel_lo | sel_hi;
   end

   // Switch overlay on the boot-vector word of the high window.
   always_comb begin
      hi_word = rom_hi[word_idx];
      if (word_idx == SW_WORD) begin
         hi_word[12:10] = hi_word[12:10] ^ {3{sw_cons}};
         hi_word[8:0]   = hi_word[8:0] | sw_offset;
      end
   end

   // Host load port; ROM contents survive reset. Reads in the same cycle see
   // the old word because both sides sample the array before the edge.
   always_ff @(posedge clk) begin
      if (rom_we) begin
         if (!rom_sel)
            rom_lo[rom_waddr[7:0]] <= rom_wdata;
         else if ({1'b0, rom_waddr[8:6]} < NSOCK_L)
            rom_hi[rom_waddr[7:0]] <= rom_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         d_q <= '0;
      else if (sel_lo)
         d_q <= rom_lo[word_idx];
      else if (sel_hi)
         d_q <= hi_word;
      else
         d_q <= '0;
   end

   // SSYN delay: saturating counter, output registered so it falls one clock
   // after select does.
   always_ff @(posedge clk) begin
      if (reset) begin
         ssyn_cnt <= '0;
         ssyn_q   <= 1'b0;
      end else begin
         if (!sel)
            ssyn_cnt <= '0;
         else if (ssyn_cnt != SSYN_MAX)
            ssyn_cnt <= ssyn_cnt + 8'd1;
         ssyn_q <= sel & (ssyn_cnt == SSYN_MAX);
      end
   end

   assign bus.bus_d_out = d_q;
   assign bus.bus_ssyn  = ssyn_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         timer     <= '0;
         msyn_cnt  <= '0;
         msyn_prev <= 1'b0;
      end else begin
         state     <= state_n;
         timer     <= timer_n;
         msyn_cnt  <= msyn_cnt_n;
         msyn_prev <= bus.bus_msyn;
      end
   end

   // Power-low restarts the override from any state and beats any MSYN edge.
   always_comb begin
      state_n    = state;
      timer_n    = timer;
      msyn_cnt_n = msyn_cnt;
      msyn_fall  = msyn_prev & ~bus.bus_msyn;
      if (bus.bus_pwr_lo) begin
         state_n    = ARMED;
         timer_n    = {{(TW-1){1'b0}}, 1'b1};
         msyn_cnt_n = '0;
      end else if (state == ARMED) begin
         timer_n = timer + {{(TW-1){1'b0}}, 1'b1};
         if (msyn_fall)
            msyn_cnt_n = msyn_cnt + 2'd1;
         if ((msyn_fall && msyn_cnt == 2'd1) || timer == TIMER_MAX)
            state_n = DONE;
      end
   end

   always_comb begin
      boot_active      = (state == ARMED) & enable & sw_ovr;
      bus.bus_addr_out = boot_active ? VECTOR : 18'd0;
   end

endmodule

// File: tb/tb_m9312_boot.sv
// tb_m9312_boot
// Randomized plus directed bench for m9312_boot. A reference model built from
// address windows, run lengths and event histories predicts every output on
// every clock; directed reads add fixed expected values.
module tb_m9312_boot;

   localparam int NSOCK       = 2;
   localparam int SSYN_DLY    = 4;
   localparam int PWR_TIMEOUT = 'o10000;
   localparam int LO_BASE     = 'o765;
   localparam int HI_BASE     = 'o773;
   localparam int SW_WORD     = 'o12;
   localparam int VECTOR      = 'o773000;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [8:0]  sw_offset;
   logic        sw_cons;
   logic        sw_ovr;
   logic        rom_we;
   logic        rom_sel;
   logic [8:0]  rom_waddr;
   logic [15:0] rom_wdata;
   logic        boot_active;

   m9312_boot_if bus();

   m9312_boot #(
      .NSOCK(NSOCK), .LO_BASE(9'(LO_BASE)), .HI_BASE(9'(HI_BASE)),
      .SW_WORD(8'(SW_WORD)), .SSYN_DLY(SSYN_DLY), .PWR_TIMEOUT(PWR_TIMEOUT),
      .VECTOR(18'(VECTOR))
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .bus(bus),
      .sw_offset(sw_offset), .sw_cons(sw_cons), .sw_ovr(sw_ovr),
      .rom_we(rom_we), .rom_sel(rom_sel), .rom_waddr(rom_waddr),
      .rom_wdata(rom_wdata), .boot_active(boot_active)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model state
   int rom_lo_m [256];
   int rom_hi_m [256];
   bit model_ok  = 1'b0;
   int edge_no   = 0;
   int last_pwr  = -1;
   int falls     = 0;
   bit prev_msyn = 1'b0;
   int sel_run   = 0;
   int exp_d     = 0;
   bit exp_ssyn  = 1'b0;
   bit armed     = 1'b0;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      if (obs !== expv) begin
         bad++;
         $display("[TB] FAIL %s: got %0o expected %0o (t=%0t)", tag, obs, expv, $time);
      end
   endtask

   // Model update for one rising edge, using inputs stable across the edge.
   task automatic modelEdge();
      int  ai, idx, w;
      bit  s_lo, s_hi, fall;
      edge_no++;
      if (reset) begin
         exp_d     = 0;
         exp_ssyn  = 1'b0;
         sel_run   = 0;
         prev_msyn = 1'b0;
         last_pwr  = -1;
         falls     = 0;
         model_ok  = 1'b1;
      end else begin
         ai   = int'(bus.bus_addr);
         idx  = (ai >> 1) & 255;
         s_lo = enable && bus.bus_msyn && ((ai >> 9) == LO_BASE);
         s_hi = enable && bus.bus_msyn && ((ai >> 9) == HI_BASE) && (((ai >> 6) & 7) < NSOCK);
         w = 0;
         if (s_lo) w = rom_lo_m[idx];
         if (s_hi) begin
            w = rom_hi_m[idx];
            if (idx == SW_WORD) begin
               w = w ^ (sw_cons ? 'o16000 : 0);
               w = w | int'(sw_offset);
            end
         end
         exp_d    = w;
         sel_run  = (s_lo || s_hi) ? sel_run + 1 : 0;
         exp_ssyn = (sel_run > SSYN_DLY);
         fall      = prev_msyn && !bus.bus_msyn;
         prev_msyn = bus.bus_msyn;
         if (bus.bus_pwr_lo) begin
            last_pwr = edge_no;
            falls    = 0;
         end else if (last_pwr >= 0 && fall) begin
            falls++;
         end
      end
      if (rom_we) begin
         if (!rom_sel)
            rom_lo_m[int'(rom_waddr) & 255] = int'(rom_wdata);
         else if ((int'(rom_waddr) >> 6) < NSOCK)
            rom_hi_m[int'(rom_waddr) & 255] = int'(rom_wdata);
      end
      armed = (last_pwr >= 0) && ((edge_no - last_pwr) < PWR_TIMEOUT) && (falls < 2);
   endtask

   task automatic step();
      bit eb;
      @(posedge clk);
      modelEdge();
      @(negedge clk);
      if (model_ok) begin
         eb = armed && enable && sw_ovr;
         checkOutput("d_out", 32'(bus.bus_d_out), 32'(exp_d));
         checkOutput("ssyn", 32'(bus.bus_ssyn), 32'(exp_ssyn));
         checkOutput("boot_active", 32'(boot_active), 32'(eb));
         checkOutput("addr_out", 32'(bus.bus_addr_out), eb ? 32'(VECTOR) : 32'd0);
      end
   endtask

   task automatic applyStimulus(input logic [17:0] addr, input logic msyn, input int n);
      bus.bus_addr = addr;
      bus.bus_msyn = msyn;
      repeat (n) step();
   endtask

   task automatic hostWrite(input logic sel, input logic [8:0] waddr, input logic [15:0] data);
      rom_we    = 1'b1;
      rom_sel   = sel;
      rom_waddr = waddr;
      rom_wdata = data;
      step();
      rom_we    = 1'b0;
   endtask

   function automatic logic [17:0] randAddr();
      logic [17:0] r;
      case ($urandom_range(0, 4))
         0:       r = {9'o765, 9'($urandom)};
         1:       r = 18'o773024;
         2:       r = {9'o773, 3'($urandom_range(0, NSOCK - 1)), 6'($urandom)};
         3:       r = {9'o773, 3'($urandom_range(NSOCK, 7)), 6'($urandom)};
         default: r = 18'($urandom);
      endcase
      return r;
   endfunction

   initial begin
      reset = 1'b1; enable = 1'b0; sw_offset = '0; sw_cons = 1'b0; sw_ovr = 1'b1;
      rom_we = 1'b0; rom_sel = 1'b0; rom_waddr = '0; rom_wdata = '0;
      bus.bus_addr = '0; bus.bus_msyn = 1'b0; bus.bus_pwr_lo = 1'b0;
      repeat (2) step();
      checkOutput("rst_ssyn", 32'(bus.bus_ssyn), 32'd0);
      checkOutput("rst_d", 32'(bus.bus_d_out), 32'd0);
      checkOutput("rst_boot", 32'(boot_active), 32'd0);
      checkOutput("rst_addr_out", 32'(bus.bus_addr_out), 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 256; i++) hostWrite(1'b0, 9'(i), 16'($urandom));
      for (int i = 0; i < NSOCK * 64; i++) hostWrite(1'b1, 9'(i), 16'($urandom));
      hostWrite(1'b0, 9'd5, 16'o012345);
      hostWrite(1'b1, 9'o012, 16'o173000);
      hostWrite(1'b1, 9'o013, 16'o054321);
      enable = 1'b1;

      // Low-ROM read with SSYN delay and release
      applyStimulus(18'o765012, 1'b1, 1);
      checkOutput("lo_d", 32'(bus.bus_d_out), 32'o12345);
      repeat (SSYN_DLY - 1) step();
      checkOutput("lo_ssyn_early", 32'(bus.bus_ssyn), 32'd0);
      step();
      checkOutput("lo_ssyn", 32'(bus.bus_ssyn), 32'd1);
      applyStimulus(18'o765012, 1'b0, 1);
      checkOutput("lo_ssyn_drop", 32'(bus.bus_ssyn), 32'd0);
      checkOutput("lo_d_drop", 32'(bus.bus_d_out), 32'd0);

      // Switch overlay
      sw_cons = 1'b1; sw_offset = 9'o20;
      applyStimulus(18'o773024, 1'b1, 1);
      checkOutput("ovl_on", 32'(bus.bus_d_out), 32'o165020);
      applyStimulus(18'o773024, 1'b0, 1);
      sw_cons = 1'b0; sw_offset = 9'o0;
      applyStimulus(18'o773024, 1'b1, 1);
      checkOutput("ovl_off", 32'(bus.bus_d_out), 32'o173000);
      applyStimulus(18'o773024, 1'b0, 1);
      sw_cons = 1'b1; sw_offset = 9'o20;
      applyStimulus(18'o773026, 1'b1, 1);
      checkOutput("ovl_other_word", 32'(bus.bus_d_out), 32'o054321);
      applyStimulus(18'o773026, 1'b0, 1);
      sw_cons = 1'b0; sw_offset = 9'o0;

      // Unpopulated socket, ignored write
      applyStimulus(18'o773200, 1'b1, 40);
      checkOutput("nosock_ssyn", 32'(bus.bus_ssyn), 32'd0);
      checkOutput("nosock_d", 32'(bus.bus_d_out), 32'd0);
      applyStimulus(18'o773200, 1'b0, 1);
      hostWrite(1'b1, 9'o005, 16'o001111);
      hostWrite(1'b1, 9'o305, 16'o007777);
      applyStimulus(18'o773012, 1'b1, 1);
      checkOutput("sock_write_ignored", 32'(bus.bus_d_out), 32'o1111);
      applyStimulus(18'o773012, 1'b0, 1);

      // Power-up vector ends on the second MSYN falling edge
      bus.bus_pwr_lo = 1'b1; step(); bus.bus_pwr_lo = 1'b0;
      checkOutput("vec_armed", 32'(boot_active), 32'd1);
      applyStimulus(18'o24, 1'b1, 3);
      checkOutput("vec_cyc1", 32'(bus.bus_addr_out), 32'o773000);
      applyStimulus(18'o24, 1'b0, 2);
      checkOutput("vec_after_fall1", 32'(boot_active), 32'd1);
      applyStimulus(18'o26, 1'b1, 3);
      checkOutput("vec_cyc2", 32'(bus.bus_addr_out), 32'o773000);
      applyStimulus(18'o26, 1'b0, 1);
      checkOutput("vec_done_boot", 32'(boot_active), 32'd0);
      checkOutput("vec_done_addr", 32'(bus.bus_addr_out), 32'd0);

      // Timeout with no MSYN, then re-arm from DONE
      bus.bus_pwr_lo = 1'b1; step(); bus.bus_pwr_lo = 1'b0;
      repeat (PWR_TIMEOUT - 1) step();
      checkOutput("tmo_last_armed", 32'(boot_active), 32'd1);
      step();
      checkOutput("tmo_done", 32'(boot_active), 32'd0);
      bus.bus_pwr_lo = 1'b1; step(); bus.bus_pwr_lo = 1'b0;
      checkOutput("rearm", 32'(boot_active), 32'd1);
      sw_ovr = 1'b0; step();
      checkOutput("ovr_off_addr", 32'(bus.bus_addr_out), 32'd0);
      sw_ovr = 1'b1; step();
      checkOutput("ovr_back_on", 32'(boot_active), 32'd1);
      reset = 1'b1; step();
      checkOutput("rst_armed", 32'(boot_active), 32'd0);
      reset = 1'b0; step();
      checkOutput("idle_after_rst", 32'(bus.bus_addr_out), 32'd0);

      // Reset in the middle of a bus cycle
      applyStimulus(18'o765012, 1'b1, SSYN_DLY + 2);
      checkOutput("mid_ssyn", 32'(bus.bus_ssyn), 32'd1);
      reset = 1'b1; step();
      checkOutput("mid_rst_ssyn", 32'(bus.bus_ssyn), 32'd0);
      checkOutput("mid_rst_d", 32'(bus.bus_d_out), 32'd0);
      reset = 1'b0;
      applyStimulus(18'o765012, 1'b0, 2);

      // Randomized traffic checked by the model every clock
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 7) == 0) begin
            if (!bus.bus_msyn) begin
               bus.bus_addr = randAddr();
               bus.bus_msyn = 1'b1;
            end else begin
               bus.bus_msyn = 1'b0;
            end
         end
         bus.bus_pwr_lo = ($urandom_range(0, 149) == 0);
         reset          = ($urandom_range(0, 399) == 0);
         rom_we         = ($urandom_range(0, 5) == 0);
         rom_sel        = 1'($urandom_range(0, 1));
         rom_waddr      = 9'($urandom_range(0, 511));
         if ($urandom_range(0, 1) == 1) rom_waddr = {1'b0, bus.bus_addr[8:1]};
         rom_wdata      = 16'($urandom);
         if ($urandom_range(0, 49) == 0) begin
            sw_cons   = 1'($urandom_range(0, 1));
            sw_offset = 9'($urandom);
            sw_ovr    = ($urandom_range(0, 3) != 0);
         end
         if ($urandom_range(0, 29) == 0) enable = ($urandom_range(0, 4) != 0);
         step();
      end

      reset = 1'b0; rom_we = 1'b0; bus.bus_pwr_lo = 1'b0; bus.bus_msyn = 1'b0;
      repeat (3) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
